// File: rtl/ir_cmd_scheduler.sv
// IR command scheduler: validates NEC frames, maps keys to game commands,
// rate-limits SHOOT and queues commands in a small FIFO drained by valid/ack.
module ir_cmd_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int COOLDOWN_CYCLES = 25000000
) (
  input  logic        master_clk,
  input  logic        resetn,
  input  logic        ir_data_ready,
  input  logic [31:0] ir_data,
  input  logic        cmd_ack,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [2:0]  direction,
  output logic        shoot_blocked,
  output logic        overflow,
  output logic [7:0]  bad_frames
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CHECK, PUSH} state_t;
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_STOP  = 3'd3,
    CMD_SHOOT = 3'd4
  } cmd_t;

  state_t        state, stateNext;
  logic          rdyQ, ackQ, rdyRise, ackRise;
  logic [15:0]   frame;
  cmd_t          keyCmd, pendCmd;
  logic          integrityOk, isRepeat, shootDrop, badFrame, goPush;
  logic [AW:0]   wrPtr, rdPtr, wrNext, rdNext;
  logic          fifoFull, popDo, pushOk;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [2:0]    headNext;
  logic [CW-1:0] cooldown;

  // Only the key and inverted-key bytes matter; the address half is ignored.
  logic unusedAddr;
  assign unusedAddr = ^ir_data[15:0];

  assign rdyRise  = ir_data_ready & ~rdyQ;
  assign ackRise  = cmd_ack & ~ackQ;
  assign popDo    = ackRise & cmd_valid;
  assign fifoFull = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign rdNext   = rdPtr + {{AW{1'b0}}, popDo};
  assign wrNext   = wrPtr + {{AW{1'b0}}, pushOk};

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    stateNext = state;
    case (state)
      IDLE:    if (rdyRise) stateNext = CHECK;
      CHECK:   stateNext = goPush ? PUSH : IDLE;
      PUSH:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    keyCmd = CMD_NONE;
    case (frame[7:0])
      8'h04:   keyCmd = CMD_LEFT;
      8'h06:   keyCmd = CMD_RIGHT;
      8'h02:   keyCmd = CMD_STOP;
      8'h05:   keyCmd = CMD_SHOOT;
      default: keyCmd = CMD_NONE;
    endcase
    integrityOk = (frame[15:8] == ~frame[7:0]);
    isRepeat    = (keyCmd == CMD_LEFT  && direction == 3'b001) ||
                  (keyCmd == CMD_RIGHT && direction == 3'b010) ||
                  (keyCmd == CMD_STOP  && direction == 3'b100);
    shootDrop   = (state == CHECK) && integrityOk && (keyCmd == CMD_SHOOT) && (cooldown != '0);
    badFrame    = (state == CHECK) && !integrityOk;
    goPush      = (state == CHECK) && integrityOk && (keyCmd != CMD_NONE) && !isRepeat && !shootDrop;
    pushOk      = (state == PUSH) && (!fifoFull || popDo);
  end

  // Head after this edge's pop/push; a push into an empty FIFO bypasses storage.
  always_comb begin
    headNext = CMD_NONE;
    if (wrNext != rdNext) begin
      if (pushOk && (wrPtr[AW-1:0] == rdNext[AW-1:0])) headNext = pendCmd;
      else                                              headNext = mem[rdNext[AW-1:0]];
    end
  end

  // NOTE: storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge master_clk) begin
    if (pushOk) mem[wrPtr[AW-1:0]] <= pendCmd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      rdyQ          <= 1'b0;
      ackQ          <= 1'b0;
      frame         <= '0;
      pendCmd       <= CMD_NONE;
      wrPtr         <= '0;
      rdPtr         <= '0;
      cmd_valid     <= 1'b0;
      cmd_code      <= 3'd0;
      direction     <= 3'b100;
      shoot_blocked <= 1'b0;
      overflow      <= 1'b0;
      bad_frames    <= 8'd0;
      cooldown      <= '0;
    end else begin
      rdyQ          <= ir_data_ready;
      ackQ          <= cmd_ack;
      wrPtr         <= wrNext;
      rdPtr         <= rdNext;
      cmd_valid     <= (wrNext != rdNext);
      cmd_code      <= headNext;
      shoot_blocked <= shootDrop;
      if (state == IDLE && rdyRise) frame <= ir_data[31:16];
      if (state == CHECK) pendCmd <= keyCmd;
      if (badFrame && bad_frames != 8'hFF) bad_frames <= bad_frames + 8'd1;
      if (state == PUSH && !pushOk) overflow <= 1'b1;
      if (pushOk) begin
        case (pendCmd)
          CMD_LEFT:  direction <= 3'b001;
          CMD_RIGHT: direction <= 3'b010;
          CMD_STOP:  direction <= 3'b100;
          default:   direction <= direction;
        endcase
      end
      if (pushOk && pendCmd == CMD_SHOOT) cooldown <= CW'(COOLDOWN_CYCLES);
      else if (cooldown != '0)            cooldown <= cooldown - CW'(1);
    end
  end

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler with a short cooldown and a 4-entry FIFO.
module tb_ir_cmd_scheduler;

  localparam logic [31:0] FR_LEFT  = 32'hFB04_0000;
  localparam logic [31:0] FR_RIGHT = 32'hF906_0000;
  localparam logic [31:0] FR_STOP  = 32'hFD02_0000;
  localparam logic [31:0] FR_SHOOT = 32'hFA05_0000;
  localparam logic [31:0] FR_BAD   = 32'h1234_0000;

  logic        master_clk = 1'b0;
  logic        resetn;
  logic        ir_data_ready;
  logic [31:0] ir_data;
  logic        cmd_ack;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  direction;
  logic        shoot_blocked;
  logic        overflow;
  logic [7:0]  bad_frames;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 master_clk = ~master_clk;

  ir_cmd_scheduler #(.FIFO_DEPTH(4), .COOLDOWN_CYCLES(8)) dut (
    .master_clk    (master_clk),
    .resetn        (resetn),
    .ir_data_ready (ir_data_ready),
    .ir_data       (ir_data),
    .cmd_ack       (cmd_ack),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .direction     (direction),
    .shoot_blocked (shoot_blocked),
    .overflow      (overflow),
    .bad_frames    (bad_frames)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge master_clk);
    resetn = 1'b0; ir_data_ready = 1'b0; cmd_ack = 1'b0;
    repeat (2) @(negedge master_clk);
    resetn = 1'b1;
    @(negedge master_clk);
  endtask

  // Ready high for 'hold' cycles, then low for one; frame is fully processed on return.
  task automatic sendFrame(input logic [31:0] d, input int hold);
    @(negedge master_clk);
    ir_data = d; ir_data_ready = 1'b1;
    repeat (hold) @(negedge master_clk);
    ir_data_ready = 1'b0;
    @(negedge master_clk);
  endtask

  task automatic ackPulse();
    @(negedge master_clk);
    cmd_ack = 1'b1;
    @(negedge master_clk);
    cmd_ack = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; ir_data_ready = 1'b0; ir_data = '0; cmd_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge master_clk);
    check("rst_direction", direction, 3'b100);
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_overflow", overflow, 0);
    check("rst_bad_frames", bad_frames, 0);
    check("rst_shoot_blocked", shoot_blocked, 0);
    resetn = 1'b1;
    @(negedge master_clk);

    // LEFT with ready held 20 cycles: latency and single push
    ir_data = FR_LEFT; ir_data_ready = 1'b1;
    repeat (2) @(negedge master_clk);
    check("left_valid_before_e2", cmd_valid, 0);
    @(negedge master_clk);
    check("left_valid_after_e2", cmd_valid, 1);
    check("left_code", cmd_code, 1);
    check("left_direction", direction, 3'b001);
    repeat (17) @(negedge master_clk);
    ir_data_ready = 1'b0;
    @(negedge master_clk);
    ackPulse();
    check("left_single_entry", cmd_valid, 0);
    check("left_code_empty", cmd_code, 0);
    sendFrame(FR_LEFT, 20);
    check("left_repeat_valid", cmd_valid, 0);
    check("left_repeat_direction", direction, 3'b001);

    // Integrity failures, saturating counter
    sendFrame(FR_BAD, 3);
    check("bad_valid", cmd_valid, 0);
    check("bad_count_1", bad_frames, 1);
    for (int i = 0; i < 299; i++) sendFrame(FR_BAD, 3);
    check("bad_count_sat", bad_frames, 255);
    check("bad_valid_after", cmd_valid, 0);

    // SHOOT cooldown
    @(negedge master_clk);
    ir_data = FR_SHOOT; ir_data_ready = 1'b1;
    repeat (2) @(negedge master_clk);
    ir_data_ready = 1'b0;
    repeat (2) @(negedge master_clk);
    check("shoot1_valid", cmd_valid, 1);
    check("shoot1_code", cmd_code, 4);
    ir_data_ready = 1'b1;
    repeat (2) @(negedge master_clk);
    check("shoot2_blocked_pulse", shoot_blocked, 1);
    ir_data_ready = 1'b0;
    @(negedge master_clk);
    check("shoot2_blocked_end", shoot_blocked, 0);
    repeat (10) @(negedge master_clk);
    sendFrame(FR_SHOOT, 3);
    check("shoot3_not_blocked", shoot_blocked, 0);
    ackPulse();
    check("shoot3_queued_valid", cmd_valid, 1);
    check("shoot3_queued_code", cmd_code, 4);
    ackPulse();
    check("shoot_fifo_drained", cmd_valid, 0);

    // Overflow: L,R,L,R fill the FIFO, STOP is dropped
    doReset();
    sendFrame(FR_LEFT, 3);
    sendFrame(FR_RIGHT, 3);
    sendFrame(FR_LEFT, 3);
    sendFrame(FR_RIGHT, 3);
    check("ovf_not_yet", overflow, 0);
    sendFrame(FR_STOP, 3);
    check("ovf_set", overflow, 1);
    check("ovf_direction", direction, 3'b010);
    check("ovf_head", cmd_code, 1);
    ackPulse();
    check("pop1_code", cmd_code, 2);
    ackPulse();
    check("pop2_code", cmd_code, 1);
    ackPulse();
    check("pop3_code", cmd_code, 2);
    check("pop3_valid", cmd_valid, 1);
    ackPulse();
    check("pop4_valid", cmd_valid, 0);
    check("pop4_code", cmd_code, 0);
    check("ovf_sticky", overflow, 1);

    // Reset while in CHECK discards the frame
    @(negedge master_clk);
    ir_data = FR_LEFT; ir_data_ready = 1'b1;
    @(negedge master_clk);
    resetn = 1'b0; ir_data_ready = 1'b0;
    repeat (2) @(negedge master_clk);
    resetn = 1'b1;
    repeat (4) @(negedge master_clk);
    check("midrst_valid", cmd_valid, 0);
    check("midrst_code", cmd_code, 0);
    check("midrst_direction", direction, 3'b100);
    check("midrst_overflow", overflow, 0);

    // Held cmd_ack pops exactly one entry
    sendFrame(FR_LEFT, 3);
    sendFrame(FR_RIGHT, 3);
    sendFrame(FR_LEFT, 3);
    @(negedge master_clk);
    cmd_ack = 1'b1;
    repeat (5) @(negedge master_clk);
    check("held_ack_valid", cmd_valid, 1);
    check("held_ack_code", cmd_code, 2);
    cmd_ack = 1'b0;
    @(negedge master_clk);
    ackPulse();
    check("held_ack_next", cmd_code, 1);
    ackPulse();
    check("held_ack_drained", cmd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
